div_issue_ctrl: RTL and testbench

Request front-end and result buffer for the SRT divider. It accepts divide requests over a valid/ready handshake and drives the divider's level-held start interface. It captures the one-cycle completion into a held output register with valid/ready. Divide-by-zero and signed overflow are resolved locally without starting the divider. A watchdog aborts a hung operation.

---
 rtl/div_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Request front-end and result buffer for the SRT divider: valid/ready intake,
// level-held divider start, held result register, local special cases and a watchdog.
module div_issue_ctrl #(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [31:0]      in_dividend,
  input  logic [31:0]      in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic             division_signed,
  output logic [31:0]      dividend,
  output logic [31:0]      divisor,
  input  logic             division_complete,
  input  logic [31:0]      quotient,
  input  logic [31:0]      remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_quotient,
  output logic [31:0]      out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             out_timeout
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WD_W   = 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_dz;
  logic                w_ovf;
  logic                w_special;
  logic                w_wd_expire;
  logic [WD_W-1:0]     r_wd;
  logic [TAG_W-1:0]    r_tag;
  logic                r_div_start;
  logic                r_div_signed;
  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_q;
  logic [DATA_W-1:0]   r_out_r;
  logic [TAG_W-1:0]    r_out_tag;
  logic                r_out_dz;
  logic                r_out_timeout;

  // Requests resolved without the divider: divide-by-zero and signed overflow.
  assign w_dz        = (in_divisor == '0);
  assign w_ovf       = in_signed && (in_dividend == 32'h8000_0000) && (in_divisor == 32'hFFFF_FFFF);
  assign w_special   = w_dz || w_ovf;
  assign w_wd_expire = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge div_clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = !flush && ((r_state == S_IDLE) || ((r_state == S_RESP) && out_ready));
    w_accept   = in_valid && w_in_ready;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_special ? S_RESP : S_BUSY;
        S_BUSY: if (division_complete || w_wd_expire) w_next = S_RESP;
        S_RESP: begin
          if (out_ready) begin
            if (w_accept) w_next = w_special ? S_RESP : S_BUSY;
            else          w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath, handshake outputs and watchdog; div_start/out_valid follow the next state.
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      r_wd          <= '0;
      r_tag         <= '0;
      r_div_start   <= 1'b0;
      r_div_signed  <= 1'b0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_out_valid   <= 1'b0;
      r_out_q       <= '0;
      r_out_r       <= '0;
      r_out_tag     <= '0;
      r_out_dz      <= 1'b0;
      r_out_timeout <= 1'b0;
    end else begin
      r_div_start <= (w_next == S_BUSY);
      r_out_valid <= (w_next == S_RESP);
      if (r_state == S_BUSY) r_wd <= r_wd + WD_W'(1);
      else                   r_wd <= '0;

      if (w_accept) begin
        r_div_signed <= in_signed;
        r_dividend   <= in_dividend;
        r_divisor    <= in_divisor;
        r_tag        <= in_tag;
        if (w_special) begin
          r_out_q       <= w_dz ? 32'hFFFF_FFFF : 32'h8000_0000;
          r_out_r       <= w_dz ? in_dividend : 32'h0;
          r_out_tag     <= in_tag;
          r_out_dz      <= w_dz;
          r_out_timeout <= 1'b0;
        end
      end else if ((r_state == S_BUSY) && !flush) begin
        // A completion in the expiry cycle wins over the watchdog.
        if (division_complete) begin
          r_out_q       <= quotient;
          r_out_r       <= remainder;
          r_out_tag     <= r_tag;
          r_out_dz      <= 1'b0;
          r_out_timeout <= 1'b0;
        end else if (w_wd_expire) begin
          r_out_q       <= '0;
          r_out_r       <= '0;
          r_out_tag     <= r_tag;
          r_out_dz      <= 1'b0;
          r_out_timeout <= 1'b1;
        end
      end

      if (flush) begin
        r_out_dz      <= 1'b0;
        r_out_timeout <= 1'b0;
      end
    end
  end

  assign in_ready        = w_in_ready;
  assign div_start       = r_div_start;
  assign division_signed = r_div_signed;
  assign dividend        = r_dividend;
  assign divisor         = r_divisor;
  assign out_valid       = r_out_valid;
  assign out_quotient    = r_out_q;
  assign out_remainder   = r_out_r;
  assign out_tag         = r_out_tag;
  assign out_dz          = r_out_dz;
  assign out_timeout     = r_out_timeout;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: directed scenarios then randomized traffic,
// with a divider stub of programmable latency and a reference model of the results.
module tb_div_issue_ctrl;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned TO    = 8;

  logic             clk = 1'b0;
  logic             resetn, flush, in_valid, in_ready, in_signed;
  logic [31:0]      in_dividend, in_divisor;
  logic [TAG_W-1:0] in_tag;
  logic             div_start, division_signed, division_complete;
  logic [31:0]      dividend, divisor, quotient, remainder;
  logic             out_valid, out_ready, out_dz, out_timeout;
  logic [31:0]      out_quotient, out_remainder;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
    .div_clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_start(div_start), .division_signed(division_signed),
    .dividend(dividend), .divisor(divisor),
    .division_complete(division_complete), .quotient(quotient), .remainder(remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag),
    .out_dz(out_dz), .out_timeout(out_timeout)
  );

  typedef struct {
    logic [31:0]      q;
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic             to;
    int unsigned      delay;
    int unsigned      acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;

  // Stub / ready control shared with the directed sequence
  logic        rand_ready = 1'b0, ready_force = 1'b1, rnd_bit = 1'b1;
  logic        stub_inject = 1'b0, stub_abort = 1'b0;
  logic        stub_special = 1'b0, stub_s = 1'b0;
  logic [31:0] stub_a = '0, stub_b = '0;
  int unsigned stub_lat = 0, stub_len = 0;
  logic        acc_ds = 1'b0;

  assign out_ready = rand_ready ? rnd_bit : ready_force;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = (($urandom % 4) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_q(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 32'hFFFF_FFFF;
    if (s) return 32'($signed(a) / $signed(b));
    return a / b;
  endfunction

  function automatic logic [31:0] ref_r(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return a;
    if (s) return 32'($signed(a) % $signed(b));
    return a % b;
  endfunction

  // Divider stub: completes on BUSY cycle stub_lat (0 = never); checks operands stay put.
  initial begin
    int unsigned cnt, lat, len;
    logic        prev, chk_len, sp, s;
    logic [31:0] a, b;
    cnt = 0; lat = 0; len = 0; prev = 1'b0; chk_len = 1'b0; sp = 1'b0; s = 1'b0; a = '0; b = '0;
    division_complete = 1'b0; quotient = '0; remainder = '0;
    forever begin
      @(negedge clk);
      division_complete = 1'b0;
      if (div_start) begin
        cnt++;
        if (cnt == 1) begin
          lat = stub_lat; len = stub_len; chk_len = !stub_special;
          sp = stub_special; s = stub_s; a = stub_a; b = stub_b;
        end
        chk("start_on_special", 32'(sp), 32'h0);
        chk("op_dividend", dividend, a);
        chk("op_divisor", divisor, b);
        chk("op_signed", 32'(division_signed), 32'(s));
        if (cnt == lat) begin
          division_complete = 1'b1;
          quotient  = ref_q(division_signed, dividend, divisor);
          remainder = ref_r(division_signed, dividend, divisor);
        end
      end else begin
        if (prev && chk_len && !stub_abort) chk("start_len", 32'(cnt), 32'(len));
        cnt = 0;
      end
      if (stub_inject) begin
        division_complete = 1'b1;
        quotient  = 32'hDEAD_BEEF;
        remainder = 32'hCAFE_F00D;
      end
      prev = div_start;
    end
  end

  // Monitor: latency on first presentation, stability under stall, fields on consume.
  logic             presented = 1'b0, stalled = 1'b0;
  logic [31:0]      h_q, h_r;
  logic [TAG_W-1:0] h_tag;
  logic             h_dz, h_to;

  always @(negedge clk) begin
    if (!resetn || !out_valid) begin
      presented = 1'b0;
      stalled   = 1'b0;
    end else begin
      if (!presented) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_result: got tag %h expected no result", out_tag);
        end else begin
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].delay));
        end
        presented = 1'b1;
      end else if (stalled) begin
        chk("hold_q", out_quotient, h_q);
        chk("hold_r", out_remainder, h_r);
        chk("hold_tag", 32'(out_tag), 32'(h_tag));
        chk("hold_flags", {30'b0, out_dz, out_timeout}, {30'b0, h_dz, h_to});
      end
      if (!out_ready) begin
        chk("in_ready_stall", 32'(in_ready), 32'h0);
        stalled = 1'b1;
        h_q = out_quotient; h_r = out_remainder; h_tag = out_tag; h_dz = out_dz; h_to = out_timeout;
      end else begin
        if (sb.size() > 0) begin
          chk("quotient", out_quotient, sb[0].q);
          chk("remainder", out_remainder, sb[0].r);
          chk("tag", 32'(out_tag), 32'(sb[0].tag));
          chk("dz", 32'(out_dz), 32'(sb[0].dz));
          chk("timeout", 32'(out_timeout), 32'(sb[0].to));
          void'(sb.pop_front());
        end
        presented = 1'b0;
        stalled   = 1'b0;
      end
    end
  end

  // Issue one request (call at posedge+1); returns at posedge+1 after acceptance.
  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input int unsigned lat);
    exp_t e;
    logic sp;
    int   k;
    sp    = (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.tag = tag;
    e.dz  = (b == 0);
    e.to  = !sp && (lat == 0);
    if (b == 0)        begin e.q = 32'hFFFF_FFFF; e.r = a; end
    else if (sp)       begin e.q = 32'h8000_0000; e.r = 32'h0; end
    else if (lat == 0) begin e.q = 32'h0; e.r = 32'h0; end
    else               begin e.q = ref_q(s, a, b); e.r = ref_r(s, a, b); end
    e.delay = sp ? 1 : (((lat == 0) ? TO : lat) + 1);
    in_valid = 1'b1; in_signed = s; in_dividend = a; in_divisor = b; in_tag = tag;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    if (k == 300) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got no in_ready expected accept of tag %h", tag);
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    sb.push_back(e);
    stub_a = a; stub_b = b; stub_s = s; stub_lat = lat; stub_special = sp;
    stub_len = (lat == 0) ? TO : lat;
    acc_ds = div_start;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", 32'(sb.size()), 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_div_start"}, 32'(div_start), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_q"}, out_quotient, 32'h0);
    chk({tag, "_out_r"}, out_remainder, 32'h0);
    chk({tag, "_out_tag_flags"}, {26'b0, out_tag, out_dz, out_timeout}, 32'h0);
    chk({tag, "_operands"}, dividend | divisor | 32'(division_signed), 32'h0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Plain unsigned, signed negative, the two local special cases
    send(1'b0, 32'd100, 32'd7, 4'd3, 4);
    drain();
    send(1'b1, 32'hFFFF_FFF9, 32'd2, 4'd1, 2);
    drain();
    send(1'b0, 32'h1234, 32'h0, 4'd2, 5);
    send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 3);
    drain();

    // Backpressure, then back-to-back accept as the result is consumed
    ready_force = 1'b0;
    send(1'b0, 32'd50, 32'd3, 4'd6, 2);
    repeat (8) begin @(posedge clk); #1; end
    ready_force = 1'b1;
    send(1'b0, 32'd77, 32'd5, 4'd5, 3);
    chk("b2b_accept_div_start", 32'(acc_ds), 32'h0);
    @(negedge clk);
    chk("b2b_next_div_start", 32'(div_start), 32'h1);
    drain();

    // Flush in the third BUSY cycle, late completion must be ignored
    send(1'b0, 32'd1000, 32'd10, 4'd7, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    stub_abort = 1'b1;
    flush = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    stub_inject = 1'b1;
    @(negedge clk);
    chk("flush_div_start", 32'(div_start), 32'h0);
    @(posedge clk); #1;
    stub_inject = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_result", 32'(out_valid), 32'h0);
    end
    @(posedge clk); #1;
    stub_abort = 1'b0;
    send(1'b0, 32'd9, 32'd4, 4'd8, 1);
    drain();

    // Watchdog expiry, completion coinciding with expiry, reset mid-BUSY
    send(1'b0, 32'd500, 32'd3, 4'd9, 0);
    drain();
    send(1'b1, 32'hFFFF_FC00, 32'd7, 4'd11, TO);
    drain();
    send(1'b0, 32'd600, 32'd3, 4'd10, 0);
    @(posedge clk); #1;
    stub_abort = 1'b1;
    sb.delete();
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_zero("mid_reset");
    resetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    stub_abort = 1'b0;

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic        s;
      logic [31:0] a, b;
      int unsigned sel;
      s   = 1'($urandom % 2);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom % 8;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = ($urandom % 16) + 1;
      else if (sel == 3) begin a = $urandom % 1000; b = ($urandom % 50) + 1; end
      if (b == 0 && sel != 0) b = 32'd1;
      repeat ($urandom % 3) begin @(posedge clk); #1; end
      send(s, a, b, TAG_W'(i), (($urandom % 10) == 0) ? 0 : (($urandom % TO) + 1));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
